// File: rtl/vga_capture_rx.sv
// rtl/vga_capture_rx.sv - VGA receive timing recovery, lock tracking and pixel capture
module vga_capture_rx #(
   parameter int SYNC_POL    = 1,
   parameter int H_PULSE     = 96,
   parameter int H_BACK      = 48,
   parameter int H_ACTIVE    = 640,
   parameter int H_TOTAL     = 800,
   parameter int V_PULSE     = 2,
   parameter int V_BACK      = 33,
   parameter int V_ACTIVE    = 480,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [3:0]  red,
   input  logic [3:0]  grn,
   input  logic [3:0]  blu,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_rgb,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        timing_err
);

   localparam logic        ACT     = 1'(SYNC_POL);
   localparam logic [10:0] H_START = 11'(H_PULSE + H_BACK);
   localparam logic [10:0] H_END   = 11'(H_PULSE + H_BACK + H_ACTIVE - 1);
   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_START = 10'(V_PULSE + V_BACK);
   localparam logic [9:0]  V_END   = 10'(V_PULSE + V_BACK + V_ACTIVE - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
   localparam int          GW      = $clog2(LOCK_FRAMES + 1);
   localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_FRAMES);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic          hs_q, hs_d, vs_q, vs_d;
   logic [11:0]   rgb_q, rgb_d;
   logic [10:0]   hcnt_q, hcnt_d;
   logic [9:0]    vcnt_q, vcnt_d;
   logic [1:0]    state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic [9:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [11:0]   pix_rgb_q, pix_rgb_d;
   logic          pix_valid_q, pix_valid_d;
   logic          frame_start_q, frame_start_d;
   logic          locked_q, locked_d;
   logic          timing_err_q, timing_err_d;

   logic h_edge, v_edge, chk_err, hact, vact;

   // Sync leading-edge detection and timing checks against the pre-clear counters
   always_comb begin
      h_edge  = (hsync == ACT) && (hs_q != ACT);
      v_edge  = h_edge && (vsync == ACT) && (vs_q != ACT);
      chk_err = (h_edge && (hcnt_q != H_LAST)) ||
                (v_edge && (vcnt_q != V_LAST)) ||
                (!h_edge && (hcnt_q == 11'd2046));
   end

   // Sampling stage: sync history, colour sample and saturating line/frame counters
   always_comb begin
      hs_d   = hs_q;
      vs_d   = vs_q;
      rgb_d  = rgb_q;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (p_tick) begin
         hs_d  = hsync;
         rgb_d = {red, grn, blu};
         if (h_edge) begin
            hcnt_d = '0;
            vs_d   = vsync;
            if (v_edge) begin
               vcnt_d = '0;
            end else if (vcnt_q != 10'h3ff) begin
               vcnt_d = vcnt_q + 10'd1;
            end
         end else if (hcnt_q != 11'h7ff) begin
            hcnt_d = hcnt_q + 11'd1;
         end
      end
   end

   // Lock FSM: an error always beats a good-frame count on the same tick
   always_comb begin
      state_d      = state_q;
      good_d       = good_q;
      timing_err_d = 1'b0;
      if (p_tick) begin
         case (state_q)
            ST_SEARCH: begin
               if (v_edge) begin
                  state_d = ST_CHECK;
                  good_d  = '0;
               end
            end
            ST_CHECK: begin
               if (chk_err) begin
                  state_d      = ST_SEARCH;
                  timing_err_d = 1'b1;
               end else if (v_edge) begin
                  good_d = good_q + GW'(1);
                  if (good_q + GW'(1) == GOOD_TARGET) begin
                     state_d = ST_LOCKED;
                  end
               end
            end
            ST_LOCKED: begin
               if (chk_err) begin
                  state_d      = ST_SEARCH;
                  timing_err_d = 1'b1;
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end
      locked_d = (state_d == ST_LOCKED);
   end

   // Output stage: qualify the registered sample and convert counters to coordinates
   always_comb begin
      hact          = (hcnt_q >= H_START) && (hcnt_q <= H_END);
      vact          = (vcnt_q >= V_START) && (vcnt_q <= V_END);
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      pix_rgb_d     = pix_rgb_q;
      pix_valid_d   = pix_valid_q;
      frame_start_d = p_tick && v_edge;
      if (p_tick) begin
         pix_valid_d = hact && vact && locked_q;
         pix_x_d     = pix_valid_d ? 10'(hcnt_q - H_START) : 10'd0;
         pix_y_d     = pix_valid_d ? (vcnt_q - V_START) : 10'd0;
         pix_rgb_d   = rgb_q;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hs_q          <= ~ACT;
         vs_q          <= ~ACT;
         rgb_q         <= '0;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         state_q       <= ST_SEARCH;
         good_q        <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_rgb_q     <= '0;
         pix_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         timing_err_q  <= 1'b0;
      end else begin
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         rgb_q         <= rgb_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         state_q       <= state_d;
         good_q        <= good_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_rgb_q     <= pix_rgb_d;
         pix_valid_q   <= pix_valid_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         timing_err_q  <= timing_err_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_rgb     = pix_rgb_q;
   assign pix_valid   = pix_valid_q;
   assign frame_start = frame_start_q;
   assign locked      = locked_q;
   assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_capture_rx.sv
// tb/tb_vga_capture_rx.sv - scoreboard bench for vga_capture_rx on a shrunken raster
module tb_vga_capture_rx;

   localparam int HP = 2, HB = 3, HA = 5, HT = 12;
   localparam int VP = 1, VB = 2, VA = 3, VT = 8;
   localparam int HS = HP + HB;
   localparam int VS = VP + VB;
   localparam int BIG = 1 << 30;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        p_tick = 1'b0;
   logic        hsync = 1'b0;
   logic        vsync = 1'b0;
   logic [3:0]  red = '0, grn = '0, blu = '0;
   logic [9:0]  pix_x, pix_y;
   logic [11:0] pix_rgb;
   logic        pix_valid, frame_start, locked, timing_err;

   int errors = 0;
   int checks = 0;
   int fs_cnt = 0;
   int te_cnt = 0;
   logic [31:0] exp_q[$];

   always #10 clk = ~clk;

   vga_capture_rx #(
      .SYNC_POL(1), .H_PULSE(HP), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
      .V_PULSE(VP), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
      .red(red), .grn(grn), .blu(blu), .pix_x(pix_x), .pix_y(pix_y),
      .pix_rgb(pix_rgb), .pix_valid(pix_valid), .frame_start(frame_start),
      .locked(locked), .timing_err(timing_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one pixel tick: inputs change on the falling edge, p_tick high for one clk
   task automatic drive(input logic hs, input logic vs, input logic [11:0] rgb);
      @(negedge clk);
      hsync  = hs;
      vsync  = vs;
      {red, grn, blu} = rgb;
      p_tick = 1'b1;
      @(negedge clk);
      p_tick = 1'b0;
   endtask

   // one frame in receiver coordinates; the first lk_lines lines are expected locked
   task automatic frame(input int nlines, input int bad_line, input int bad_len,
                        input int lk_lines, input int max_ticks);
      int t;
      int len;
      logic [9:0]  x, y;
      logic [11:0] rgb;
      t = 0;
      for (int v = 0; v < nlines; v++) begin
         len = (v == bad_line) ? bad_len : HT;
         for (int h = 0; h < len; h++) begin
            if (t >= max_ticks) return;
            x   = 10'(h - HS);
            y   = 10'(v - VS);
            rgb = {x[3:0], y[3:0], 4'hA};
            if (v < lk_lines && h >= HS && h < HS + HA && v >= VS && v < VS + VA &&
                t + 1 < max_ticks)
               exp_q.push_back({x, y, rgb});
            drive(h < HP, v < VP, rgb);
            t++;
         end
      end
   endtask

   // monitor: one scoreboard pop per output beat, plus pulse counting
   initial begin : monitor
      logic was_tick;
      logic [31:0] act, exp;
      forever begin
         @(posedge clk);
         was_tick = p_tick;
         @(negedge clk);
         if (frame_start === 1'b1) fs_cnt++;
         if (timing_err === 1'b1) te_cnt++;
         if (was_tick && pix_valid === 1'b1) begin
            act = {pix_x, pix_y, pix_rgb};
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat_unexpected: got %0h expected no beat", act);
            end else begin
               exp = exp_q.pop_front();
               check("pixel_beat", act, exp);
            end
         end
      end
   end

   initial begin : stim
      repeat (3) @(negedge clk);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_timing_err", 32'(timing_err), 32'd0);
      check("rst_pix_xy", {12'd0, pix_x, pix_y}, 32'd0);
      check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
      reset = 1'b1;

      // acquisition: lock on the third v-edge
      frame(VT, -1, HT, 0, BIG);
      frame(VT, -1, HT, 0, BIG);
      check("lock_before_3rd_vedge", 32'(locked), 32'd0);
      frame(VT, -1, HT, VT, BIG);
      check("lock_after_3rd_vedge", 32'(locked), 32'd1);
      frame(VT, -1, HT, VT, BIG);
      check("fs_count_nominal", 32'(fs_cnt), 32'd4);
      check("te_count_nominal", 32'(te_cnt), 32'd0);

      // short line while locked
      frame(VT, 4, HT - 1, 5, BIG);
      check("short_line_te", 32'(te_cnt), 32'd1);
      check("short_line_locked", 32'(locked), 32'd0);
      check("short_line_valid", 32'(pix_valid), 32'd0);
      frame(VT, -1, HT, 0, BIG);
      frame(VT, -1, HT, 0, BIG);
      check("relock_pending", 32'(locked), 32'd0);
      frame(VT, -1, HT, VT, BIG);
      check("relock_done", 32'(locked), 32'd1);

      // hsync stuck deasserted: watchdog
      for (int i = 0; i < 2100; i++) drive(1'b0, 1'b0, 12'h000);
      check("watchdog_te", 32'(te_cnt), 32'd2);
      check("watchdog_locked", 32'(locked), 32'd0);
      check("watchdog_no_fs", 32'(fs_cnt), 32'd8);

      // short frame while in CHECK
      frame(VT - 1, -1, HT, 0, BIG);
      frame(VT, -1, HT, 0, BIG);
      check("short_frame_te", 32'(te_cnt), 32'd3);
      check("short_frame_locked", 32'(locked), 32'd0);
      frame(VT, -1, HT, 0, BIG);
      frame(VT, -1, HT, 0, BIG);
      check("short_frame_no_lock", 32'(locked), 32'd0);
      frame(VT, -1, HT, VT, BIG);
      check("short_frame_relock", 32'(locked), 32'd1);

      // reset mid-line while locked
      frame(VT, -1, HT, VT, 3 * HT + 8);
      check("pre_reset_valid", 32'(pix_valid), 32'd1);
      check("pre_reset_pixel", {pix_x, pix_y, pix_rgb}, {10'd1, 10'd0, 12'h10A});
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("async_rst_valid", 32'(pix_valid), 32'd0);
      check("async_rst_locked", 32'(locked), 32'd0);
      check("async_rst_pixel", {pix_x, pix_y, pix_rgb}, 32'd0);
      check("async_rst_pending", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      frame(VT, -1, HT, 0, BIG);
      frame(VT, -1, HT, 0, BIG);
      check("post_reset_lock_pending", 32'(locked), 32'd0);
      frame(VT, -1, HT, VT, BIG);
      check("post_reset_locked", 32'(locked), 32'd1);
      frame(VT, -1, HT, VT, BIG);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("fs_count_total", 32'(fs_cnt), 32'd18);
      check("te_count_total", 32'(te_cnt), 32'd3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
